// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader: boot-time instruction-memory loader.
//
// Receives a program as a byte stream (16-bit LE word count N, then N 32-bit
// LE words), packs bytes into words, writes them to the instruction memory and
// holds the CPU (o_cpu_run=0) until a complete, valid image has been written.
// Also owns the memory address mux between the loader and the CPU fetch path.
//
// Optional feature, macro IM_LOADER_CSUM_EN: a trailing checksum byte (XOR of
// all header and data bytes) is required after the last word; a mismatch sets
// o_load_err and leaves the CPU stalled.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous, active-high reset
//   i_load_start   single-cycle pulse, begins a load (ignored while busy)
//   i_byte_valid   i_byte_data valid this cycle
//   i_byte_data    stream byte
//   o_byte_ready   loader accepts a byte this cycle
//   i_cpu_addr     IF-stage fetch byte address
//   o_mem_addr     byte address to instruction memory
//   o_mem_we       memory write enable, one cycle per word
//   o_mem_wdata    word to write
//   o_cpu_run      1 = CPU may execute
//   o_load_busy    load in progress
//   o_load_err     sticky error, cleared by the next accepted load start
// -----------------------------------------------------------------------------
module im_loader #(
    parameter int unsigned NMEM = 256,
    parameter int unsigned AW   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    input  logic [31:0] i_cpu_addr,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    output logic        o_cpu_run,
    output logic        o_load_busy,
    output logic        o_load_err
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StDone,
        StCsum
    } state_e;

    // State entered once the image body is complete (or empty).
`ifdef IM_LOADER_CSUM_EN
    localparam state_e StFinish = StCsum;
`else
    localparam state_e StFinish = StDone;
`endif

    state_e        r_state;
    state_e        w_state_d;
    logic [15:0]   r_count;
    logic [AW-1:0] r_word_idx;
    logic [1:0]    r_byte_idx;
    logic [31:0]   r_word;
    logic          r_cpu_run;
    logic          r_load_err;

    logic          w_xfer;
    logic [15:0]   w_hdr_n;
    logic          w_too_big;
    logic          w_last_word;

`ifdef IM_LOADER_CSUM_EN
    logic [7:0]    r_csum;
    logic          w_csum_ok;
`endif

    assign w_xfer      = i_byte_valid & o_byte_ready;
    // Full word count as it will be once the high header byte is latched.
    assign w_hdr_n     = {i_byte_data, r_count[7:0]};
    assign w_too_big   = 32'(w_hdr_n) > NMEM;
    assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_count);

`ifdef IM_LOADER_CSUM_EN
    assign w_csum_ok   = (i_byte_data == r_csum);
`endif

    // Next-state and handshake decode.
    always_comb begin
        w_state_d    = r_state;
        o_byte_ready = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_load_start) w_state_d = StHdr0;
            end
            StHdr0: begin
                o_byte_ready = 1'b1;
                if (i_byte_valid) w_state_d = StHdr1;
            end
            StHdr1: begin
                o_byte_ready = 1'b1;
                if (i_byte_valid) begin
                    if (w_hdr_n == 16'd0) w_state_d = StFinish;
                    else if (w_too_big)   w_state_d = StIdle;
                    else                  w_state_d = StData;
                end
            end
            StData: begin
                o_byte_ready = 1'b1;
                if (i_byte_valid && r_byte_idx == 2'd3) w_state_d = StWrite;
            end
            StWrite: begin
                w_state_d = w_last_word ? StFinish : StData;
            end
            StDone: begin
                w_state_d = StIdle;
            end
`ifdef IM_LOADER_CSUM_EN
            StCsum: begin
                o_byte_ready = 1'b1;
                if (i_byte_valid) w_state_d = w_csum_ok ? StDone : StIdle;
            end
`endif
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_cpu_run  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                StIdle: begin
                    if (i_load_start) begin
                        r_load_err <= 1'b0;
                        r_cpu_run  <= 1'b0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                    end
                end
                StHdr0: begin
                    if (w_xfer) r_count[7:0] <= i_byte_data;
                end
                StHdr1: begin
                    if (w_xfer) begin
                        r_count[15:8] <= i_byte_data;
                        if (w_too_big) r_load_err <= 1'b1;
                    end
                end
                StData: begin
                    if (w_xfer) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= i_byte_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                StWrite: begin
                    r_word_idx <= r_word_idx + AW'(1);
                    r_byte_idx <= '0;
                end
                StDone: begin
                    r_cpu_run <= 1'b1;
                end
`ifdef IM_LOADER_CSUM_EN
                StCsum: begin
                    if (w_xfer && !w_csum_ok) r_load_err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef IM_LOADER_CSUM_EN
    // Running XOR over header and data bytes of the current load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_csum <= '0;
        end else if (r_state == StIdle && i_load_start) begin
            r_csum <= '0;
        end else if (w_xfer && (r_state == StHdr0 || r_state == StHdr1 || r_state == StData)) begin
            r_csum <= r_csum ^ i_byte_data;
        end
    end
`endif

    assign o_mem_we    = (r_state == StWrite);
    assign o_mem_wdata = r_word;
    assign o_load_busy = (r_state != StIdle);
    assign o_cpu_run   = r_cpu_run;
    assign o_load_err  = r_load_err;
    assign o_mem_addr  = o_load_busy ? 32'({r_word_idx, 2'b00}) : i_cpu_addr;

endmodule

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader: self-checking bench for im_loader.
// Table of load scenarios with expected results, hand-written corner-case
// sequences (gapped stream with a stray load_start, async reset mid-load),
// then randomized loads checked against a stream-level reference model.
// -----------------------------------------------------------------------------
module tb_im_loader;

    localparam int unsigned NMEM = 256;
    localparam int unsigned AW   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic [31:0] cpu_addr = 32'h0000_1234;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        load_busy;
    logic        load_err;

    always #5 clk = ~clk;

    im_loader #(
        .NMEM (NMEM),
        .AW   (AW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_start (load_start),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_byte_ready (byte_ready),
        .i_cpu_addr   (cpu_addr),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .o_cpu_run    (cpu_run),
        .o_load_busy  (load_busy),
        .o_load_err   (load_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Every cycle with mem_we high is logged; a stretched pulse shows up as an extra entry.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          exp_err;
        bit          exp_run;
        int          exp_writes;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // All stimulus tasks start and end just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("byte_ready_wait", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        @(negedge clk);
        check("start_busy", 32'(load_busy), 32'd1);
        check("start_run_low", 32'(cpu_run), 32'd0);
        check("start_err_clr", 32'(load_err), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // The load must settle within three cycles of its final byte.
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (load_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_latency", 32'(load_busy), 32'd0);
    endtask

    task automatic run_load(input int n, input logic [31:0] words[$], input int gmin,
                            input int gmax, input bit mid_pulse, input logic [7:0] csum_flip,
                            input bit exp_err, input bit exp_run, input int exp_writes);
        logic [7:0] s[$];
        int         nw;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        if (n <= int'(NMEM)) begin
            for (int k = 0; k < n; k++) begin
                for (int b = 0; b < 4; b++) s.push_back(words[k][8*b +: 8]);
            end
`ifdef IM_LOADER_CSUM_EN
            begin
                logic [7:0] x = 8'h00;
                foreach (s[i]) x ^= s[i];
                s.push_back(x ^ csum_flip);
            end
`endif
        end
        foreach (s[i]) begin
            send_byte(s[i]);
            if (mid_pulse && i == 3) begin
                load_start = 1'b1;
                @(posedge clk);
                #1;
                load_start = 1'b0;
            end
            repeat ($urandom_range(gmax, gmin)) @(posedge clk);
            if (gmax > 0) #1;
        end
        wait_idle();
        check("load_err", 32'(load_err), 32'(exp_err));
        check("cpu_run", 32'(cpu_run), 32'(exp_run));
        check("busy_end", 32'(load_busy), 32'd0);
        check("write_count", 32'(wr_addr_q.size()), 32'(exp_writes));
        nw = (wr_addr_q.size() < exp_writes) ? wr_addr_q.size() : exp_writes;
        for (int k = 0; k < nw; k++) begin
            check($sformatf("wr%0d_addr", k), wr_addr_q[k], 32'(4 * k));
            check($sformatf("wr%0d_data", k), wr_data_q[k], words[k]);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[7];
    logic [31:0] wq[$];

    initial begin
        vecs[0] = '{2,     32'h2402_0005, 32'h0000_0000, 1'b0, 1'b1, 2};
        vecs[1] = '{257,   32'h0,         32'h0,         1'b1, 1'b0, 0};
        vecs[2] = '{0,     32'h0,         32'h0,         1'b0, 1'b1, 0};
        vecs[3] = '{1,     32'h1122_3344, 32'h0,         1'b0, 1'b1, 1};
        vecs[4] = '{256,   32'hCAFE_F00D, 32'h0000_0001, 1'b0, 1'b1, 256};
        vecs[5] = '{65535, 32'h0,         32'h0,         1'b1, 1'b0, 0};
        vecs[6] = '{3,     32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1, 3};

        // Reset values, checked while reset is held.
        #2;
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_run", 32'(cpu_run), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_addr_pass", mem_addr, 32'h0000_1234);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven loads.
        foreach (vecs[i]) begin
            wq.delete();
            if (vecs[i].n <= int'(NMEM)) begin
                for (int k = 0; k < vecs[i].n; k++) begin
                    if (k == 0)      wq.push_back(vecs[i].w0);
                    else if (k == 1) wq.push_back(vecs[i].w1);
                    else             wq.push_back(32'hA500_0000 ^ (32'(k) * 32'h0101_0101));
                end
            end
            run_load(vecs[i].n, wq, 0, 0, 1'b0, 8'h00, vecs[i].exp_err, vecs[i].exp_run,
                     vecs[i].exp_writes);
            cpu_addr = 32'h8 + 32'(16 * i);
            #1;
            check($sformatf("v%0d_addr_pass", i), mem_addr, 32'h8 + 32'(16 * i));
        end

        // Gapped stream plus a stray load_start mid-load.
        wq = {32'hDEAD_BEEF};
        run_load(1, wq, 1, 1, 1'b1, 8'h00, 1'b0, 1'b1, 1);

        // Asynchronous reset after three data bytes.
        wr_addr_q.delete();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_run", 32'(cpu_run), 32'd0);
        check("arst_ready", 32'(byte_ready), 32'd0);
        check("arst_busy", 32'(load_busy), 32'd0);
        check("arst_no_write", 32'(wr_addr_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        wq = {32'h1234_5678};
        run_load(1, wq, 0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1);

`ifdef IM_LOADER_CSUM_EN
        // Correct trailing byte is 0x45; flipping by 0x45 sends 0x00.
        wq = {32'h1122_3344};
        run_load(1, wq, 0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1);
        run_load(1, wq, 0, 0, 1'b0, 8'h45, 1'b1, 1'b0, 1);
`endif

        // Randomized loads against the stream-level model.
        for (int r = 0; r < 15; r++) begin
            int n;
            bit err;
            if ($urandom_range(4, 0) == 0) n = int'($urandom_range(65535, NMEM + 1));
            else                           n = int'($urandom_range(10, 1));
            err = (n > int'(NMEM));
            wq.delete();
            if (!err) for (int k = 0; k < n; k++) wq.push_back($urandom);
            run_load(n, wq, 0, 2, 1'b0, 8'h00, err, !err, err ? 0 : n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time controller for the instruction memory: receives a program as a byte stream, packs bytes into 32-bit words, and drives the memory's write port.
- Owns the memory address mux between the loader and the CPU fetch address.
- Holds the CPU (cpu_run=0) until a complete, valid image is written.
- Sits between the host byte source (UART receiver or testbench) and the instruction memory / IF stage.

Parameters:
NMEM, 256, instruction memory depth in 32-bit words
AW, 8, word-index width; must satisfy 2^AW >= NMEM

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load_start  in  1  single-cycle pulse; begins a load
byte_valid  in  1  byte_data valid this cycle
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts a byte this cycle
cpu_addr  in  32  IF-stage fetch byte address
mem_addr  out  32  byte address to instruction memory
mem_we  out  1  memory write enable, one cycle per word
mem_wdata  out  32  word to write
cpu_run  out  1  1 = CPU may execute; 0 = CPU stalled
load_busy  out  1  load in progress
load_err  out  1  sticky error flag, cleared by next load_start

Behaviour:
- Byte transfer occurs only when byte_valid & byte_ready are both high on a rising clk edge. byte_data is sampled on that edge.
- Stream format:
  - Two header bytes: word count N, 16-bit little-endian.
  - Then N words, 4 bytes each, little-endian (first byte goes to bits [7:0]).
- Reset values: state IDLE, cpu_run=0, load_busy=0, load_err=0, mem_we=0, mem_wdata=0, byte_ready=0, word index=0, byte index=0.
- State machine:
  - IDLE: byte_ready=0. load_start -> HDR0; on that edge, clear load_err and drop cpu_run to 0.
  - HDR0: byte_ready=1. On transfer, latch N[7:0] -> HDR1.
  - HDR1: byte_ready=1. On transfer, latch N[15:8].
    - If N == 0 -> DONE.
    - If N > NMEM -> set load_err, go to IDLE; cpu_run stays 0.
    - Otherwise -> DATA.
  - DATA: byte_ready=1. Shift the byte into the word at lane byte_idx, then byte_idx++. When the 4th byte transfers -> WRITE.
  - WRITE: byte_ready=0. mem_we=1 for exactly one cycle with mem_wdata = assembled word. Then word_idx++ and byte_idx=0.
    - If word_idx+1 == N -> DONE (or CSUM when the optional feature is compiled in).
    - Otherwise -> DATA.
  - DONE: cpu_run=1 from the next cycle, then -> IDLE.
- load_busy=1 in every state except IDLE.
- mem_addr:
  - While load_busy: {(30-AW) zeros, word_idx, 2'b00}.
  - Otherwise: cpu_addr, combinational passthrough.
- Write latency: the 4th byte of word k is accepted at edge t; mem_we is high in cycle t+1 with mem_addr = 4k.
- load_start while load_busy is ignored. load_start in IDLE after a completed load restarts: cpu_run falls the cycle after the pulse.
- An idle stream (byte_valid=0) holds the current state indefinitely; there is no timeout.
- Asynchronous rst mid-load returns everything to reset values immediately. Partially written memory contents are left as-is.
- word_idx never exceeds NMEM-1, because N is validated in HDR1.

Optional Feature:
Macro: IM_LOADER_CSUM_EN
- Defined:
  - After the last WRITE, enter state CSUM (byte_ready=1) and accept one byte.
  - The expected value is the XOR of all header and data bytes.
  - Match -> DONE. Mismatch -> set load_err, go to IDLE with cpu_run=0.
  - For N == 0, HDR1 goes to CSUM instead of DONE.
- Not defined: no CSUM state; the stream ends after the last data byte, and all other behaviour is identical.

Test Plan:
- Reset, then stream N=2 (bytes 02 00), words 0x24020005 and 0x00000000 -> mem_we pulses at mem_addr 0x0 (wdata 0x24020005) and 0x4 (wdata 0x0); cpu_run=1 one cycle after DONE; mem_addr then follows cpu_addr=0x8.
- Header N=257 (bytes 01 01) with NMEM=256 -> load_err=1, no mem_we pulses, cpu_run=0, load_busy=0.
- N=0 (bytes 00 00, no csum) -> no mem_we, cpu_run=1 within 2 cycles after the second header byte.
- byte_valid toggled every other cycle during a 1-word load, and a second load_start pulse mid-load -> identical write result; the extra pulse is ignored.
- rst asserted after 3 data bytes -> cpu_run=0, byte_ready=0, load_busy=0 asynchronously. A fresh full load afterwards succeeds with word 0 written at address 0.
- Csum build only, N=1, word 0x11223344: trailing byte 0x45 -> cpu_run=1; trailing byte 0x00 -> load_err=1, cpu_run=0.
